// File: rtl/output_layer_mac.sv
// Output-layer MAC: streams hidden activations against weight rows, accumulates
// N_OUT class scores in parallel, then scans them serially for the argmax class.
module output_layer_mac #(
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int A_W    = 16,
    parameter int W_W    = 16,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hid_valid,
    input  logic [A_W-1:0]         hid_data,
    output logic                   hid_ready,
    output logic [ADDR_W-1:0]      w_addr,
    input  logic [N_OUT*W_W-1:0]   w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             pred,
    output logic [ACC_W-1:0]       max_score
);

    localparam int P_W = A_W + W_W;

    typedef enum logic [1:0] {ACCUM, DRAIN, ARGMAX, DONE} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        cnt;
    logic [ADDR_W-1:0]        addr_q;
    logic [3:0]               idx;
    logic signed [A_W-1:0]    act_q;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  best;
    logic signed [ACC_W-1:0]  acc    [N_OUT];
    logic signed [W_W-1:0]    lane_s [N_OUT];
    logic signed [P_W-1:0]    prod_s [N_OUT];
    logic signed [ACC_W-1:0]  addend [N_OUT];
    logic                     xfer;
    logic                     last;

    assign hid_ready = (state == ACCUM) && rst_n;
    assign xfer      = hid_valid && hid_ready;
    assign last      = (cnt == ADDR_W'(N_HID - 1));
    assign w_addr    = xfer ? cnt : addr_q;
    assign max_score = best;

    // The weight row arrives one cycle after its address, so the activation is
    // registered at the transfer and multiplied against the row in the next cycle.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            lane_s[k] = $signed(w_data[k*W_W +: W_W]);
            prod_s[k] = P_W'(act_q) * P_W'(lane_s[k]);
            addend[k] = ACC_W'(prod_s[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            addr_q    <= '0;
            idx       <= '0;
            act_q     <= '0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            pred      <= '0;
            best      <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                acc[k] <= '0;
            end
        end else begin
            mac_en <= xfer;
            if (xfer) begin
                act_q  <= hid_data;
                addr_q <= cnt;
                cnt    <= last ? '0 : cnt + 1'b1;
            end
            if (mac_en) begin
                for (int k = 0; k < N_OUT; k++) begin
                    acc[k] <= acc[k] + addend[k];
                end
            end

            case (state)
                ACCUM: begin
                    if (xfer && last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= ARGMAX;
                    idx   <= '0;
                end
                ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if (idx == '0 || acc[idx] > best) begin
                        best <= acc[idx];
                        pred <= idx;
                    end
                    if (idx == 4'(N_OUT - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        for (int k = 0; k < N_OUT; k++) begin
                            acc[k] <= '0;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Scenario bench for output_layer_mac: a reference model pushes expected results
// to a scoreboard that is popped when the DUT presents out_valid.
module tb_output_layer_mac;

    localparam int N_HID  = 32;
    localparam int N_OUT  = 10;
    localparam int A_W    = 16;
    localparam int W_W    = 16;
    localparam int ACC_W  = 40;
    localparam int ADDR_W = 7;

    logic                   clk;
    logic                   rst_n;
    logic                   hid_valid;
    logic [A_W-1:0]         hid_data;
    logic                   hid_ready;
    logic [ADDR_W-1:0]      w_addr;
    logic [N_OUT*W_W-1:0]   w_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             pred;
    logic [ACC_W-1:0]       max_score;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]       pred;
        logic [ACC_W-1:0] score;
    } exp_t;

    exp_t sb[$];

    logic signed [A_W-1:0] acts        [N_HID];
    logic signed [W_W-1:0] wts         [N_HID][N_OUT];
    logic [ADDR_W-1:0]     addr_seen   [N_HID];
    logic [ADDR_W-1:0]     bubble_addr [N_HID];

    output_layer_mac #(
        .N_HID(N_HID), .N_OUT(N_OUT), .A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hid_valid(hid_valid), .hid_data(hid_data),
        .hid_ready(hid_ready), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
        .out_ready(out_ready), .pred(pred), .max_score(max_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous weight memory with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            w_data[k*W_W +: W_W] <= wts[int'(w_addr) % N_HID][k];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_weights(input int mode);
        for (int j = 0; j < N_HID; j++) begin
            for (int k = 0; k < N_OUT; k++) begin
                case (mode)
                    0:       wts[j][k] = W_W'(k);
                    1:       wts[j][k] = '0;
                    default: wts[j][k] = (k == 3) ? W_W'(-5) : W_W'(1);
                endcase
            end
        end
    endtask

    task automatic set_acts(input int mode);
        for (int j = 0; j < N_HID; j++) begin
            case (mode)
                0:       acts[j] = A_W'(1);
                1:       acts[j] = A_W'(-1);
                default: acts[j] = A_W'($urandom);
            endcase
        end
    endtask

    task automatic push_expected();
        longint                  acc [N_OUT];
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] best;
        exp_t                    e;
        for (int k = 0; k < N_OUT; k++) acc[k] = 0;
        for (int j = 0; j < N_HID; j++) begin
            for (int k = 0; k < N_OUT; k++) begin
                acc[k] += longint'(acts[j]) * longint'(wts[j][k]);
            end
        end
        e.pred = '0;
        best   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            a = acc[k][ACC_W-1:0];
            if (k == 0 || a > best) begin
                best   = a;
                e.pred = 4'(k);
            end
        end
        e.score = best;
        sb.push_back(e);
    endtask

    task automatic send_frame(input bit toggle, output bit ok);
        int j;
        int guard;
        bit bub;
        j = 0;
        guard = 0;
        bub = 1'b0;
        while (j < N_HID && guard < 4 * N_HID) begin
            @(negedge clk);
            guard++;
            if (toggle && bub) begin
                hid_valid = 1'b0;
                bub = 1'b0;
                #1;
                bubble_addr[j] = w_addr;
            end else begin
                hid_valid = 1'b1;
                hid_data  = acts[j];
                #1;
                if (hid_ready) begin
                    addr_seen[j] = w_addr;
                    j++;
                    bub = toggle;
                end
            end
        end
        ok = (j == N_HID);
        @(negedge clk);
        hid_valid = 1'b0;
    endtask

    task automatic wait_result(output int n, output bit ok);
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        hid_valid = 1'b1;
        hid_data  = A_W'(5);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (hid_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_hid_ready got %b want 0", hid_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (pred !== 4'd0) begin errors++; $display("[TB] FAIL reset_pred got %0d want 0", pred); end
        checks++;
        if (max_score !== '0) begin errors++; $display("[TB] FAIL reset_max_score got %0d want 0", $signed(max_score)); end
        checks++;
        if (w_addr !== '0) begin errors++; $display("[TB] FAIL reset_w_addr got %0d want 0", w_addr); end
        @(negedge clk);
        hid_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(0);
        set_acts(0);
        out_ready = 1'b1;
        push_expected();
        send_frame(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL basic_accept got %0d want 1", ok); end
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (n !== N_OUT + 2) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", n, N_OUT + 2); end
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL basic_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL basic_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
        for (int j = 0; j < N_HID; j++) begin
            checks++;
            if (addr_seen[j] !== ADDR_W'(j)) begin errors++; $display("[TB] FAIL basic_w_addr[%0d] got %0d want %0d", j, addr_seen[j], j); end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_release_valid got %b want 0", out_valid); end
        checks++;
        if (hid_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_release_ready got %b want 1", hid_ready); end
    endtask

    task automatic test_zero_weights();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(1);
        set_acts(2);
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (!okr) begin errors++; $display("[TB] FAIL zero_timeout got %0d want 1", okr); end
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL zero_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL zero_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
    endtask

    task automatic test_negative();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(2);
        set_acts(1);
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL neg_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL neg_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
    endtask

    task automatic test_bubbles();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(0);
        set_acts(0);
        push_expected();
        send_frame(1'b1, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (n !== N_OUT + 2) begin errors++; $display("[TB] FAIL bubble_latency got %0d want %0d", n, N_OUT + 2); end
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL bubble_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL bubble_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
        for (int j = 1; j < N_HID; j++) begin
            checks++;
            if (bubble_addr[j] !== ADDR_W'(j - 1)) begin errors++; $display("[TB] FAIL bubble_w_addr_hold[%0d] got %0d want %0d", j, bubble_addr[j], j - 1); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        out_ready = 1'b0;
        set_weights(0);
        set_acts(0);
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hid_valid = 1'b1;
            hid_data  = A_W'($urandom);
            #1;
            checks++;
            if (out_valid !== 1'b1 || pred !== e.pred || max_score !== e.score || hid_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d got valid=%b pred=%0d score=%0d ready=%b want valid=1 pred=%0d score=%0d ready=0",
                         c, out_valid, pred, $signed(max_score), hid_ready, e.pred, $signed(e.score));
            end
        end
        hid_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got %b want 0", out_valid); end
        set_weights(2);
        set_acts(1);
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL after_hold_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL after_hold_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(0);
        set_acts(0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hid_valid = 1'b1;
            hid_data  = acts[i];
        end
        @(negedge clk);
        hid_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (hid_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_hid_ready got %b want 0", hid_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (w_addr !== '0) begin errors++; $display("[TB] FAIL midrst_w_addr got %0d want 0", w_addr); end
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (addr_seen[0] !== '0) begin errors++; $display("[TB] FAIL midrst_first_addr got %0d want 0", addr_seen[0]); end
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL midrst_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL midrst_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
    endtask

    task automatic test_reset_argmax();
        bit ok;
        bit okr;
        int n;
        exp_t e;
        set_weights(0);
        set_acts(0);
        send_frame(1'b0, ok);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pred !== 4'd0) begin errors++; $display("[TB] FAIL argrst_state got valid=%b pred=%0d want valid=0 pred=0", out_valid, pred); end
        set_weights(2);
        set_acts(1);
        push_expected();
        send_frame(1'b0, ok);
        wait_result(n, okr);
        e = sb.pop_front();
        checks++;
        if (pred !== e.pred) begin errors++; $display("[TB] FAIL argrst_pred got %0d want %0d", pred, e.pred); end
        checks++;
        if (max_score !== e.score) begin errors++; $display("[TB] FAIL argrst_score got %0d want %0d", $signed(max_score), $signed(e.score)); end
    endtask

    initial begin
        hid_valid = 1'b0;
        hid_data  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        set_weights(1);
        test_reset();
        test_basic();
        test_zero_weights();
        test_negative();
        test_bubbles();
        test_backpressure();
        test_reset_midframe();
        test_reset_argmax();
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
